// File: rtl/dnn_acc_axi_mem_slave.sv
// AXI3-style 64-bit memory responder backing the accelerator's user_axi port.
// Independent read and write channels, one outstanding burst each.
module dnn_acc_axi_mem_slave #(
    parameter int          MEM_DEPTH_LOG2 = 12,
    parameter logic [31:0] BASE_ADDR      = 32'h0000_0000
) (
    input  logic        user_clk,
    input  logic        user_reset_n,
    input  logic [31:0] user_axi_araddr,
    input  logic [1:0]  user_axi_arburst,
    input  logic        user_axi_arid,
    input  logic [3:0]  user_axi_arlen,
    input  logic [2:0]  user_axi_arsize,
    input  logic [3:0]  user_axi_arcache,
    input  logic        user_axi_arvalid,
    output logic        user_axi_arready,
    input  logic [31:0] user_axi_awaddr,
    input  logic [1:0]  user_axi_awburst,
    input  logic        user_axi_awid,
    input  logic [3:0]  user_axi_awlen,
    input  logic [2:0]  user_axi_awsize,
    input  logic [3:0]  user_axi_awcache,
    input  logic        user_axi_awvalid,
    output logic        user_axi_awready,
    input  logic [63:0] user_axi_wdata,
    input  logic [7:0]  user_axi_wstrb,
    input  logic        user_axi_wlast,
    input  logic        user_axi_wvalid,
    output logic        user_axi_wready,
    output logic        user_axi_bid,
    output logic [1:0]  user_axi_bresp,
    output logic        user_axi_bvalid,
    input  logic        user_axi_bready,
    output logic [63:0] user_axi_rdata,
    output logic        user_axi_rid,
    output logic [1:0]  user_axi_rresp,
    output logic        user_axi_rlast,
    output logic        user_axi_rvalid,
    input  logic        user_axi_rready
);

    localparam int AW    = MEM_DEPTH_LOG2;
    localparam int DEPTH = 1 << AW;

    logic [63:0] mem [DEPTH];

    function automatic logic in_range(input logic [31:0] a);
        return ((a - BASE_ADDR) >> (AW + 3)) == 32'd0;
    endfunction

    function automatic logic [AW-1:0] word_of(input logic [31:0] a);
        return AW'((a - BASE_ADDR) >> 3);
    endfunction

    function automatic logic [1:0] resp_of(input logic [31:0] a,
                                           input logic [2:0]  size,
                                           input logic [1:0]  burst);
        if (!in_range(a))
            return 2'b11;
        if (size != 3'b011 || burst[1])
            return 2'b10;
        return 2'b00;
    endfunction

    // Holds ready low through the reset cycle itself.
    logic rst_done;

    always_ff @(posedge user_clk)
        rst_done <= user_reset_n;

    typedef enum logic {R_IDLE, R_DATA} r_state_t;

    r_state_t    r_state, r_next;
    logic [31:0] r_addr;
    logic [3:0]  r_len, r_beat;
    logic [1:0]  r_burst;
    logic [2:0]  r_size;
    logic        ar_hs, r_hs, r_load;
    logic [31:0] r_nxt_addr, beat_addr;
    logic [2:0]  beat_size;
    logic [1:0]  beat_burst, beat_resp;

    assign ar_hs  = (r_state == R_IDLE) && rst_done && user_axi_arvalid;
    assign r_hs   = user_axi_rvalid && user_axi_rready;
    assign r_load = ar_hs || (r_hs && !user_axi_rlast);

    assign r_nxt_addr = (r_burst == 2'b01) ? r_addr + 32'd8 : r_addr;
    assign beat_addr  = ar_hs ? user_axi_araddr  : r_nxt_addr;
    assign beat_size  = ar_hs ? user_axi_arsize  : r_size;
    assign beat_burst = ar_hs ? user_axi_arburst : r_burst;
    assign beat_resp  = resp_of(beat_addr, beat_size, beat_burst);

    always_ff @(posedge user_clk) begin
        if (!user_reset_n)
            r_state <= R_IDLE;
        else
            r_state <= r_next;
    end

    always_comb begin
        r_next           = r_state;
        user_axi_arready = 1'b0;
        unique case (r_state)
            R_IDLE: begin
                user_axi_arready = rst_done;
                if (ar_hs)
                    r_next = R_DATA;
            end
            R_DATA: begin
                if (r_hs && user_axi_rlast)
                    r_next = R_IDLE;
            end
        endcase
    end

    // The RAM read sees pre-edge contents, so a same-edge write is not visible.
    always_ff @(posedge user_clk) begin
        if (!user_reset_n) begin
            user_axi_rvalid <= 1'b0;
            user_axi_rdata  <= '0;
            user_axi_rresp  <= '0;
            user_axi_rlast  <= 1'b0;
            user_axi_rid    <= 1'b0;
            r_addr          <= '0;
            r_len           <= '0;
            r_beat          <= '0;
            r_burst         <= '0;
            r_size          <= '0;
        end else begin
            if (ar_hs) begin
                r_len        <= user_axi_arlen;
                r_burst      <= user_axi_arburst;
                r_size       <= user_axi_arsize;
                user_axi_rid <= user_axi_arid;
                r_beat       <= '0;
            end else if (r_load) begin
                r_beat <= r_beat + 4'd1;
            end
            if (r_load) begin
                r_addr          <= beat_addr;
                user_axi_rvalid <= 1'b1;
                user_axi_rresp  <= beat_resp;
                user_axi_rdata  <= (beat_resp == 2'b00) ?
                                   mem[word_of(beat_addr)] : 64'd0;
                user_axi_rlast  <= ar_hs ? (user_axi_arlen == 4'd0)
                                         : ((r_beat + 4'd1) == r_len);
            end else if (r_hs) begin
                user_axi_rvalid <= 1'b0;
            end
        end
    end

    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;

    w_state_t    w_state, w_next;
    logic [31:0] w_addr;
    logic [3:0]  w_len, w_cnt;
    logic [1:0]  w_burst;
    logic [2:0]  w_size;
    logic        w_dec, w_mis;
    logic        aw_hs, w_hs, w_mis_beat, mem_we;
    logic [1:0]  w_resp_beat;

    assign aw_hs = (w_state == W_IDLE) && rst_done && user_axi_awvalid;
    assign w_hs  = (w_state == W_DATA) && user_axi_wvalid;

    assign w_resp_beat = resp_of(w_addr, w_size, w_burst);
    assign w_mis_beat  = user_axi_wlast ? (w_cnt != w_len) : (w_cnt == w_len);
    assign mem_we      = w_hs && user_reset_n && (w_resp_beat == 2'b00) &&
                         (w_cnt <= w_len);

    always_ff @(posedge user_clk) begin
        if (!user_reset_n)
            w_state <= W_IDLE;
        else
            w_state <= w_next;
    end

    always_comb begin
        w_next           = w_state;
        user_axi_awready = 1'b0;
        user_axi_wready  = 1'b0;
        user_axi_bvalid  = 1'b0;
        unique case (w_state)
            W_IDLE: begin
                user_axi_awready = rst_done;
                if (aw_hs)
                    w_next = W_DATA;
            end
            W_DATA: begin
                user_axi_wready = 1'b1;
                if (user_axi_wvalid && user_axi_wlast)
                    w_next = W_RESP;
            end
            W_RESP: begin
                user_axi_bvalid = 1'b1;
                if (user_axi_bready)
                    w_next = W_IDLE;
            end
            default: w_next = W_IDLE;
        endcase
    end

    always_ff @(posedge user_clk) begin
        if (!user_reset_n) begin
            w_addr         <= '0;
            w_len          <= '0;
            w_cnt          <= '0;
            w_burst        <= '0;
            w_size         <= '0;
            w_dec          <= 1'b0;
            w_mis          <= 1'b0;
            user_axi_bid   <= 1'b0;
            user_axi_bresp <= '0;
        end else if (aw_hs) begin
            w_addr       <= user_axi_awaddr;
            w_len        <= user_axi_awlen;
            w_burst      <= user_axi_awburst;
            w_size       <= user_axi_awsize;
            user_axi_bid <= user_axi_awid;
            w_cnt        <= '0;
            w_dec        <= 1'b0;
            w_mis        <= 1'b0;
        end else if (w_hs) begin
            w_addr <= (w_burst == 2'b01) ? w_addr + 32'd8 : w_addr;
            w_cnt  <= (w_cnt == 4'd15) ? w_cnt : w_cnt + 4'd1;
            w_dec  <= w_dec | (w_resp_beat == 2'b11);
            w_mis  <= w_mis | w_mis_beat;
            if (user_axi_wlast) begin
                if (w_dec || w_resp_beat == 2'b11)
                    user_axi_bresp <= 2'b11;
                else if (w_mis || w_mis_beat || w_resp_beat == 2'b10)
                    user_axi_bresp <= 2'b10;
                else
                    user_axi_bresp <= 2'b00;
            end
        end
    end

    always_ff @(posedge user_clk) begin
        if (mem_we) begin
            for (int i = 0; i < 8; i++) begin
                if (user_axi_wstrb[i])
                    mem[word_of(w_addr)][8*i +: 8] <= user_axi_wdata[8*i +: 8];
            end
        end
    end

    logic unused_cache;
    assign unused_cache = ^{user_axi_arcache, user_axi_awcache};

endmodule
